// File: rtl/core_piplsu.sv
// rtl/core_piplsu.sv - load/store access stage: DCache req/ack, byte lanes, ack watchdog
// Optional feature macro: KAYRV32_MISALIGN_TRAP_EN (misaligned ops trap instead of force-align)

`ifndef OP_LB
`define OP_LB  5'd1
`endif
`ifndef OP_LH
`define OP_LH  5'd2
`endif
`ifndef OP_LW
`define OP_LW  5'd3
`endif
`ifndef OP_LBU
`define OP_LBU 5'd4
`endif
`ifndef OP_LHU
`define OP_LHU 5'd5
`endif
`ifndef OP_SB
`define OP_SB  5'd6
`endif
`ifndef OP_SH
`define OP_SH  5'd7
`endif
`ifndef OP_SW
`define OP_SW  5'd8
`endif

module core_piplsu #(
  parameter int TMO_W      = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iValid,
  input  logic [4:0]  iDecodedOP,
  input  logic [31:0] iAddr,
  input  logic [31:0] iStoreDATA,
  input  logic [4:0]  iDregADDR,
  output logic        oStall,
  output logic        oDCacheREQ,
  output logic        oDCacheWE,
  output logic [31:0] oDCacheADDR,
  output logic [3:0]  oDCacheBE,
  output logic [31:0] oDCacheWDATA,
  input  logic        iDCacheACK,
  input  logic [31:0] iDCacheRDATA,
  output logic [4:0]  oDregADDR,
  output logic [31:0] oDregDATA,
  output logic        oRW,
  output logic        oValid,
  output logic        oBusErr
`ifdef KAYRV32_MISALIGN_TRAP_EN
  ,
  output logic        oMisalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t state, stateNext;

  logic inMem, inLoad, inStore, inByte, inHalf, inWord;
  logic [1:0]  aEff;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic        accept;
  logic        trapNow;

  logic        loadReg, byteReg, halfReg;
  logic [1:0]  aReg;
  logic [31:0] sdReg;
  logic [4:0]  rdReg;
  logic [TMO_W-1:0] cnt;
  logic        terminal;
  logic [31:0] shifted, loadData;

`ifdef KAYRV32_MISALIGN_TRAP_EN
  logic misReg;
`endif

  // Decode the incoming op into access class and direction
  always_comb begin
    inMem = 1'b1; inLoad = 1'b0; inStore = 1'b0;
    inByte = 1'b0; inHalf = 1'b0; inWord = 1'b0;
    case (iDecodedOP)
      `OP_LB, `OP_LBU: begin inLoad = 1'b1; inByte = 1'b1; end
      `OP_LH, `OP_LHU: begin inLoad = 1'b1; inHalf = 1'b1; end
      `OP_LW:          begin inLoad = 1'b1; inWord = 1'b1; end
      `OP_SB:          begin inStore = 1'b1; inByte = 1'b1; end
      `OP_SH:          begin inStore = 1'b1; inHalf = 1'b1; end
      `OP_SW:          begin inStore = 1'b1; inWord = 1'b1; end
      default:         inMem = 1'b0;
    endcase
  end

  // Lane selection: halves and words are force-aligned to their natural boundary
  always_comb begin
    aEff      = iAddr[1:0];
    beNext    = 4'b0001 << iAddr[1:0];
    wdataNext = {4{iStoreDATA[7:0]}};
    if (inHalf) begin
      aEff      = {iAddr[1], 1'b0};
      beNext    = iAddr[1] ? 4'b1100 : 4'b0011;
      wdataNext = {2{iStoreDATA[15:0]}};
    end else if (inWord) begin
      aEff      = 2'b00;
      beNext    = 4'b1111;
      wdataNext = iStoreDATA;
    end
    if (inLoad) wdataNext = 32'h0;
  end

  assign accept = (state == IDLE) && iValid && inMem;

`ifdef KAYRV32_MISALIGN_TRAP_EN
  assign trapNow = (inHalf && iAddr[0]) || (inWord && (iAddr[1:0] != 2'b00));
`else
  assign trapNow = 1'b0;
`endif

  assign terminal = (cnt == TMO_W'(TMO_CYCLES - 1));

  // Right-align the read word and clear lanes above the access size
  always_comb begin
    shifted  = iDCacheRDATA >> {aReg, 3'b000};
    loadData = shifted;
    if (byteReg)      loadData = {24'h0, shifted[7:0]};
    else if (halfReg) loadData = {16'h0, shifted[15:0]};
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    stateNext  = state;
    oStall     = 1'b0;
    oDCacheREQ = 1'b0;
    oValid     = 1'b0;
    oBusErr    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          oStall    = 1'b1;
          stateNext = trapNow ? DONE : REQ;
        end
      end
      REQ: begin
        oStall     = 1'b1;
        oDCacheREQ = 1'b1;
        if (iDCacheACK)    stateNext = DONE;
        else if (terminal) stateNext = ERR;
      end
      DONE: begin
        oValid    = 1'b1;
        stateNext = IDLE;
      end
      ERR: begin
        oValid    = 1'b1;
        oBusErr   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef KAYRV32_MISALIGN_TRAP_EN
  assign oMisalign = (state == DONE) && misReg;
`endif

  // Operation capture, watchdog counter and MA-facing result registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      loadReg      <= 1'b0;
      byteReg      <= 1'b0;
      halfReg      <= 1'b0;
      aReg         <= 2'b00;
      sdReg        <= 32'h0;
      rdReg        <= 5'h0;
      cnt          <= '0;
      oDCacheWE    <= 1'b0;
      oDCacheADDR  <= 32'h0;
      oDCacheBE    <= 4'h0;
      oDCacheWDATA <= 32'h0;
      oDregADDR    <= 5'h0;
      oDregDATA    <= 32'h0;
      oRW          <= 1'b0;
`ifdef KAYRV32_MISALIGN_TRAP_EN
      misReg       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        loadReg      <= inLoad;
        byteReg      <= inByte;
        halfReg      <= inHalf;
        aReg         <= aEff;
        sdReg        <= iStoreDATA;
        rdReg        <= iDregADDR;
        cnt          <= '0;
        oDCacheWE    <= inStore;
        oDCacheADDR  <= {iAddr[31:2], 2'b00};
        oDCacheBE    <= beNext;
        oDCacheWDATA <= wdataNext;
`ifdef KAYRV32_MISALIGN_TRAP_EN
        misReg       <= trapNow;
`endif
        if (trapNow) begin
          oDregADDR <= iDregADDR;
          oDregDATA <= 32'h0;
          oRW       <= inLoad;
        end
      end else if (state == REQ) begin
        if (iDCacheACK) begin
          oDregADDR <= rdReg;
          oDregDATA <= loadReg ? loadData : sdReg;
          oRW       <= loadReg;
        end else if (terminal) begin
          oDregADDR <= rdReg;
          oDregDATA <= 32'h0;
          oRW       <= loadReg;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_piplsu.sv
// tb/tb_core_piplsu.sv - directed self-checking bench for core_piplsu
module tb_core_piplsu;

  localparam logic [4:0] OpLB = 5'd1, OpLH = 5'd2, OpLW = 5'd3, OpLBU = 5'd4;
  localparam logic [4:0] OpLHU = 5'd5, OpSB = 5'd6, OpSH = 5'd7, OpSW = 5'd8;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iValid = 1'b0;
  logic [4:0]  iDecodedOP = 5'd0;
  logic [31:0] iAddr = 32'h0;
  logic [31:0] iStoreDATA = 32'h0;
  logic [4:0]  iDregADDR = 5'h0;
  logic        oStall, oDCacheREQ, oDCacheWE;
  logic [31:0] oDCacheADDR, oDCacheWDATA;
  logic [3:0]  oDCacheBE;
  logic        iDCacheACK = 1'b0;
  logic [31:0] iDCacheRDATA = 32'h0;
  logic [4:0]  oDregADDR;
  logic [31:0] oDregDATA;
  logic        oRW, oValid, oBusErr;
`ifdef KAYRV32_MISALIGN_TRAP_EN
  logic        oMisalign;
`endif

  int checks = 0;
  int errors = 0;

  core_piplsu #(.TMO_W(8), .TMO_CYCLES(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iDecodedOP(iDecodedOP),
    .iAddr(iAddr), .iStoreDATA(iStoreDATA), .iDregADDR(iDregADDR),
    .oStall(oStall), .oDCacheREQ(oDCacheREQ), .oDCacheWE(oDCacheWE),
    .oDCacheADDR(oDCacheADDR), .oDCacheBE(oDCacheBE), .oDCacheWDATA(oDCacheWDATA),
    .iDCacheACK(iDCacheACK), .iDCacheRDATA(iDCacheRDATA),
    .oDregADDR(oDregADDR), .oDregDATA(oDregDATA), .oRW(oRW),
    .oValid(oValid), .oBusErr(oBusErr)
`ifdef KAYRV32_MISALIGN_TRAP_EN
    , .oMisalign(oMisalign)
`endif
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd);
    iValid = 1'b1; iDecodedOP = op; iAddr = addr; iStoreDATA = sd; iDregADDR = rd;
  endtask

  initial begin
    // reset state
    tick(); tick();
    iRST = 1'b0;
    #1;
    check("rst_stall", oStall, 0);
    check("rst_req", oDCacheREQ, 0);
    check("rst_valid", oValid, 0);
    check("rst_buserr", oBusErr, 0);
    check("rst_addr", oDCacheADDR, 0);
    check("rst_be", oDCacheBE, 0);
    check("rst_wdata", oDCacheWDATA, 0);
    check("rst_dregdata", oDregDATA, 0);
    check("rst_rw", oRW, 0);

    // non-memory op is ignored
    issue(5'd0, 32'h100, 32'h0, 5'd1);
    #1 check("nonmem_stall", oStall, 0);
    tick(); iValid = 1'b0;
    check("nonmem_req", oDCacheREQ, 0);

    // reset while REQ is outstanding
    issue(OpLW, 32'h100, 32'h0, 5'd3);
    #1 check("rstreq_accept_stall", oStall, 1);
    tick(); iValid = 1'b0;
    check("rstreq_req", oDCacheREQ, 1);
    iRST = 1'b1;
    tick(); iRST = 1'b0;
    #1;
    check("rstreq_req_low", oDCacheREQ, 0);
    check("rstreq_valid", oValid, 0);
    check("rstreq_stall", oStall, 0);
    check("rstreq_addr", oDCacheADDR, 0);
    tick();
    check("rstreq_valid_after", oValid, 0);

    // SB at 0x1003, ack on second REQ cycle
    issue(OpSB, 32'h1003, 32'h000000A5, 5'd0);
    #1 check("sb_stall_c1", oStall, 1);
    tick(); iValid = 1'b0;
    check("sb_stall_c2", oStall, 1);
    check("sb_req", oDCacheREQ, 1);
    check("sb_addr", oDCacheADDR, 32'h1000);
    check("sb_be", oDCacheBE, 4'b1000);
    check("sb_wdata", oDCacheWDATA, 32'hA5A5A5A5);
    check("sb_we", oDCacheWE, 1);
    tick();
    iDCacheACK = 1'b1;
    #1 check("sb_stall_c3", oStall, 1);
    check("sb_addr_stable", oDCacheADDR, 32'h1000);
    tick(); iDCacheACK = 1'b0;
    #1;
    check("sb_valid", oValid, 1);
    check("sb_stall_done", oStall, 0);
    check("sb_rw", oRW, 0);
    check("sb_dregdata", oDregDATA, 32'h000000A5);
    tick();
    check("sb_valid_pulse", oValid, 0);
    check("sb_rw_held", oRW, 0);

    // ack outside REQ is ignored
    iDCacheACK = 1'b1;
    tick(); iDCacheACK = 1'b0;
    check("stray_ack_valid", oValid, 0);
    check("stray_ack_req", oDCacheREQ, 0);

    // LH at 0x2002, immediate ack
    issue(OpLH, 32'h2002, 32'h0, 5'd5);
    tick(); iValid = 1'b0;
    check("lh_be", oDCacheBE, 4'b1100);
    check("lh_we", oDCacheWE, 0);
    check("lh_wdata", oDCacheWDATA, 0);
    iDCacheACK = 1'b1; iDCacheRDATA = 32'hBEEF1234;
    tick(); iDCacheACK = 1'b0;
    check("lh_valid", oValid, 1);
    check("lh_data", oDregDATA, 32'h0000BEEF);
    check("lh_rw", oRW, 1);
    check("lh_rd", oDregADDR, 5'd5);
    tick();

    // LBU at 0x4001
    issue(OpLBU, 32'h4001, 32'h0, 5'd6);
    tick(); iValid = 1'b0;
    check("lbu_be", oDCacheBE, 4'b0010);
    iDCacheACK = 1'b1; iDCacheRDATA = 32'h11223344;
    tick(); iDCacheACK = 1'b0;
    check("lbu_data", oDregDATA, 32'h00000033);
    tick();

    // SH at 0x0006
    issue(OpSH, 32'h0006, 32'hDEAD5678, 5'd2);
    tick(); iValid = 1'b0;
    check("sh_be", oDCacheBE, 4'b1100);
    check("sh_wdata", oDCacheWDATA, 32'h56785678);
    iDCacheACK = 1'b1;
    tick(); iDCacheACK = 1'b0;
    check("sh_valid", oValid, 1);
    tick();

    // LW with no ack: watchdog after 4 REQ cycles
    issue(OpLW, 32'h50, 32'h0, 5'd7);
    tick(); iValid = 1'b0;
    check("tmo_req1", oDCacheREQ, 1);
    tick(); check("tmo_req2", oDCacheREQ, 1);
    tick(); check("tmo_req3", oDCacheREQ, 1);
    tick(); check("tmo_req4", oDCacheREQ, 1);
    check("tmo_noerr_yet", oBusErr, 0);
    tick();
    check("tmo_req_off", oDCacheREQ, 0);
    check("tmo_buserr", oBusErr, 1);
    check("tmo_valid", oValid, 1);
    check("tmo_data", oDregDATA, 0);
    check("tmo_stall", oStall, 0);
    check("tmo_rd", oDregADDR, 5'd7);
    tick();
    check("tmo_buserr_pulse", oBusErr, 0);

    // ack on the terminal-count cycle wins
    issue(OpLW, 32'h60, 32'h0, 5'd8);
    tick(); iValid = 1'b0;
    tick(); tick(); tick();
    iDCacheACK = 1'b1; iDCacheRDATA = 32'hCAFEF00D;
    tick(); iDCacheACK = 1'b0;
    check("tc_buserr", oBusErr, 0);
    check("tc_valid", oValid, 1);
    check("tc_data", oDregDATA, 32'hCAFEF00D);
    tick();

    // misaligned LW at 0x3001
    issue(OpLW, 32'h3001, 32'h0, 5'd9);
    iDCacheRDATA = 32'h12345678;
    tick(); iValid = 1'b0;
`ifdef KAYRV32_MISALIGN_TRAP_EN
    check("mis_req", oDCacheREQ, 0);
    check("mis_valid", oValid, 1);
    check("mis_flag", oMisalign, 1);
    check("mis_data", oDregDATA, 0);
    tick();
    check("mis_flag_pulse", oMisalign, 0);
`else
    check("mis_req", oDCacheREQ, 1);
    check("mis_addr", oDCacheADDR, 32'h3000);
    check("mis_be", oDCacheBE, 4'b1111);
    iDCacheACK = 1'b1;
    tick(); iDCacheACK = 1'b0;
    check("mis_valid", oValid, 1);
    check("mis_data", oDregDATA, 32'h12345678);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
